mmss_countdown: RTL and testbench
=================================

// Module: mmss_countdown
// PURPOSE
//   Loadable BCD mm:ss countdown timer: decrements once per tick strobe, borrowing seconds -> minutes.
//   Down-counting/borrow counterpart of the up-counting carry chain used by the clock display path.
//   Sits between the 1 Hz tick generator and the 7-seg display driver; done pulse feeds the alarm/beeper.
// PARAMETERS
//   MIN_T_MAX  5   highest minutes-tens value (5 -> 59:59 max; 9 -> 99:59 max)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  synchronous, active-high reset
//   tick       in   1  one-cycle 1 Hz strobe; decrement request
//   load       in   1  load ld_* digits into counter
//   ld_min_t   in   4  load value, minutes tens
//   ld_min_o   in   4  load value, minutes ones
//   ld_sec_t   in   4  load value, seconds tens
//   ld_sec_o   in   4  load value, seconds ones
//   start      in   1  start/resume countdown
//   pause      in   1  suspend countdown
//   min_t      out  4  current minutes tens (BCD)
//   min_o      out  4  current minutes ones (BCD)
//   sec_t      out  4  current seconds tens (BCD)
//   sec_o      out  4  current seconds ones (BCD)
//   running    out  1  high while state == RUN
//   done       out  1  one-cycle pulse when count reaches 00:00
//   expired    out  1  level, high in EXPIRED until load or rst
// BEHAVIOUR
//   Reset: all digits 0, state IDLE, running=0, done=0, expired=0. rst dominates every other input.
//   States: IDLE, RUN, PAUSED, EXPIRED. All outputs registered.
//   load: accepted in IDLE/PAUSED/EXPIRED -> digits updated next edge, state -> IDLE, expired=0.
//     Ignored in RUN. Out-of-range digits clamp: ones >9 -> 9, sec tens >5 -> 5, min tens >MIN_T_MAX -> MIN_T_MAX.
//   start: IDLE/PAUSED with nonzero count -> RUN next edge. Ignored if count == 00:00, in RUN, in EXPIRED.
//   load and start same cycle: load wins, start ignored.
//   pause: RUN -> PAUSED; ignored elsewhere. tick and pause same cycle in RUN: decrement applied AND enter PAUSED.
//   tick in RUN: count -= 1 s on next edge. Borrow chain: sec_o 0->9 borrows sec_t; sec_t 0->5 borrows min_o;
//     min_o 0->9 borrows min_t; min_t decrements. tick outside RUN ignored.
//   Reaching 00:00: on the edge that writes 00:00, state -> EXPIRED, done=1 for exactly that one cycle
//     (coincident with display showing 00:00), expired=1 from same edge; running=0 from same edge.
//   00:00 never wraps to 59:59; ticks in EXPIRED ignored.
//   rst mid-count: next edge 00:00 / IDLE, any pending done suppressed.
// STRUCTURE
//   Shared package: state encoding (IDLE=0, RUN=1, PAUSED=2, EXPIRED=3), BCD_ONES_MAX=9, SEC_TENS_MAX=5.
//   Sub-module bcd_down_digit #(MAX): clk, rst, load, din, dec -> q[3:0], bo (comb: dec && q==0);
//     wraps 0->MAX on dec; four instances chained bo->dec; top holds FSM, clamp, zero detect, done reg.
// TESTING
//   rst, load 01:00, start, 1 tick -> 00:59, running=1, done=0.
//   load 00:02, start, 2 ticks -> 00:01 then 00:00 with done=1 one cycle, expired=1, running=0; extra tick -> stays 00:00.
//   load 10:00, start, tick -> 09:59 (full borrow chain); load with ld_sec_t=7, ld_sec_o=12 -> sec 59.
//   load 00:05, start, tick+pause same cycle -> 00:04, PAUSED; 3 ticks -> 00:04; start, tick -> 00:03.
//   start with count 00:00 -> stays IDLE, running=0, done=0; load+start same cycle -> IDLE with new value.
//   RUN at 00:01, rst asserted in the tick cycle -> 00:00, IDLE, done=0, expired=0.

Source files
------------

// File: rtl/mmss_countdown_pkg.sv
// Shared definitions for the mm:ss countdown timer: FSM encoding, BCD digit limits
// and the load-value clamp helper.
package mmss_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/mmss_countdown_bcd_down_digit.sv
// One loadable BCD down-counting digit; wraps 0 -> MAX on decrement and raises a
// combinational borrow so digits can be chained least-significant first.
module bcd_down_digit #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       dec,
  output logic [3:0] q,
  output logic       bo
);

  localparam logic [3:0] WRAP = 4'(MAX);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load)     q_d = din;
    else if (dec) q_d = (q_q == 4'd0) ? WRAP : q_q - 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) q_q <= 4'd0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign bo = dec && (q_q == 4'd0);

endmodule

// File: rtl/mmss_countdown.sv
// Loadable BCD mm:ss countdown timer: one-second decrement per tick while running,
// seconds borrow into minutes, stops at 00:00 with a one-cycle done pulse.
module mmss_countdown
  import mmss_countdown_pkg::*;
#(
  parameter int unsigned MIN_T_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_o,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_o,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MIN_T_MAX);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   running_q, expired_q;
  logic   load_en, dec_en;
  logic   cnt_zero, cnt_one;
  logic   sec_o_bo, sec_t_bo, min_o_bo;
  logic   unused_min_t_bo;

  assign cnt_zero = (min_t == 4'd0) && (min_o == 4'd0) && (sec_t == 4'd0) && (sec_o == 4'd0);
  assign cnt_one  = (min_t == 4'd0) && (min_o == 4'd0) && (sec_t == 4'd0) && (sec_o == 4'd1);

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value held and no latch is inferred.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load_en = 1'b0;
    dec_en  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_PAUSED: begin
        if (load) begin
          load_en = 1'b1;
          state_d = ST_IDLE;
        end else if (start && !cnt_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) dec_en = 1'b1;
        // Hitting zero wins over a coincident pause: the count is finished.
        if (tick && cnt_one) begin
          state_d = ST_EXPIRED;
          done_d  = 1'b1;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end
      end
      ST_EXPIRED: begin
        if (load) begin
          load_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_EXPIRED);
    end
  end

  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

  bcd_down_digit #(.MAX(9)) u_sec_o (
    .clk(clk), .rst(rst), .load(load_en),
    .din(bcd_clamp(ld_sec_o, BCD_ONES_MAX)),
    .dec(dec_en), .q(sec_o), .bo(sec_o_bo)
  );

  bcd_down_digit #(.MAX(5)) u_sec_t (
    .clk(clk), .rst(rst), .load(load_en),
    .din(bcd_clamp(ld_sec_t, SEC_TENS_MAX)),
    .dec(sec_o_bo), .q(sec_t), .bo(sec_t_bo)
  );

  bcd_down_digit #(.MAX(9)) u_min_o (
    .clk(clk), .rst(rst), .load(load_en),
    .din(bcd_clamp(ld_min_o, BCD_ONES_MAX)),
    .dec(sec_t_bo), .q(min_o), .bo(min_o_bo)
  );

  // The top borrow can never fire: decrements stop on the edge that writes 00:00.
  bcd_down_digit #(.MAX(MIN_T_MAX)) u_min_t (
    .clk(clk), .rst(rst), .load(load_en),
    .din(bcd_clamp(ld_min_t, MIN_TENS_MAX)),
    .dec(min_o_bo), .q(min_t), .bo(unused_min_t_bo)
  );

endmodule

// File: tb/tb_mmss_countdown.sv
// Scoreboard bench for mmss_countdown: each cycle's expected display and flags are
// queued as stimulus is driven and popped after the following clock edge.
module tb_mmss_countdown;

  logic       clk = 1'b0;
  logic       rst, tick, load, start, pause;
  logic [3:0] ld_min_t, ld_min_o, ld_sec_t, ld_sec_o;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running, done, expired;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic [2:0]  flags;  // {running, done, expired}
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mmss_countdown #(.MIN_T_MAX(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .ld_min_t(ld_min_t), .ld_min_o(ld_min_o), .ld_sec_t(ld_sec_t), .ld_sec_o(ld_sec_o),
    .start(start), .pause(pause),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .running(running), .done(done), .expired(expired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic cyc(input string tag, input logic r, input logic t, input logic l,
                     input logic [15:0] ld, input logic s, input logic p,
                     input logic [15:0] exp_cnt, input logic [2:0] exp_flags);
    exp_t e;
    @(negedge clk);
    rst = r; tick = t; load = l; start = s; pause = p;
    {ld_min_t, ld_min_o, ld_sec_t, ld_sec_o} = ld;
    sb.push_back('{tag: tag, cnt: exp_cnt, flags: exp_flags});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_cnt"},   {16'd0, min_t, min_o, sec_t, sec_o}, {16'd0, e.cnt});
      check({e.tag, "_flags"}, {29'd0, running, done, expired},      {29'd0, e.flags});
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    {ld_min_t, ld_min_o, ld_sec_t, ld_sec_o} = 16'h0000;

    //   tag            rst  tick load ld       start pause  exp_cnt  {run,done,exp}
    cyc("reset",        1,   0,   0,   16'h0000, 0,   0,     16'h0000, 3'b000);
    cyc("load_0100",    0,   0,   1,   16'h0100, 0,   0,     16'h0100, 3'b000);
    cyc("start_0100",   0,   0,   0,   16'h0000, 1,   0,     16'h0100, 3'b100);
    cyc("tick_0059",    0,   1,   0,   16'h0000, 0,   0,     16'h0059, 3'b100);
    cyc("hold_run",     0,   0,   0,   16'h0000, 0,   0,     16'h0059, 3'b100);
    cyc("load_in_run",  0,   0,   1,   16'h0002, 0,   0,     16'h0059, 3'b100);
    cyc("pause_0059",   0,   0,   0,   16'h0000, 0,   1,     16'h0059, 3'b000);

    cyc("load_0002",    0,   0,   1,   16'h0002, 0,   0,     16'h0002, 3'b000);
    cyc("start_0002",   0,   0,   0,   16'h0000, 1,   0,     16'h0002, 3'b100);
    cyc("tick_0001",    0,   1,   0,   16'h0000, 0,   0,     16'h0001, 3'b100);
    cyc("tick_0000",    0,   1,   0,   16'h0000, 0,   0,     16'h0000, 3'b011);
    cyc("done_drops",   0,   0,   0,   16'h0000, 0,   0,     16'h0000, 3'b001);
    cyc("tick_expired", 0,   1,   0,   16'h0000, 0,   0,     16'h0000, 3'b001);
    cyc("start_expired",0,   0,   0,   16'h0000, 1,   0,     16'h0000, 3'b001);

    cyc("load_1000",    0,   0,   1,   16'h1000, 0,   0,     16'h1000, 3'b000);
    cyc("start_1000",   0,   0,   0,   16'h0000, 1,   0,     16'h1000, 3'b100);
    cyc("tick_0959",    0,   1,   0,   16'h0000, 0,   0,     16'h0959, 3'b100);
    cyc("pause_0959",   0,   0,   0,   16'h0000, 0,   1,     16'h0959, 3'b000);
    cyc("clamp_sec",    0,   0,   1,   16'h037C, 0,   0,     16'h0359, 3'b000);
    cyc("clamp_min",    0,   0,   1,   16'h9F20, 0,   0,     16'h5920, 3'b000);
    cyc("start_5920",   0,   0,   0,   16'h0000, 1,   0,     16'h5920, 3'b100);
    cyc("tick_5919",    0,   1,   0,   16'h0000, 0,   0,     16'h5919, 3'b100);
    cyc("pause_5919",   0,   0,   0,   16'h0000, 0,   1,     16'h5919, 3'b000);

    cyc("load_0005",    0,   0,   1,   16'h0005, 0,   0,     16'h0005, 3'b000);
    cyc("start_0005",   0,   0,   0,   16'h0000, 1,   0,     16'h0005, 3'b100);
    cyc("tick_pause",   0,   1,   0,   16'h0000, 0,   1,     16'h0004, 3'b000);
    for (int i = 0; i < 3; i++)
      cyc("tick_paused",0,   1,   0,   16'h0000, 0,   0,     16'h0004, 3'b000);
    cyc("resume",       0,   0,   0,   16'h0000, 1,   0,     16'h0004, 3'b100);
    cyc("tick_0003",    0,   1,   0,   16'h0000, 0,   0,     16'h0003, 3'b100);
    cyc("pause_0003",   0,   0,   0,   16'h0000, 0,   1,     16'h0003, 3'b000);

    cyc("load_0000",    0,   0,   1,   16'h0000, 0,   0,     16'h0000, 3'b000);
    cyc("start_zero",   0,   0,   0,   16'h0000, 1,   0,     16'h0000, 3'b000);
    cyc("load_start",   0,   0,   1,   16'h0030, 1,   0,     16'h0030, 3'b000);
    cyc("tick_idle",    0,   1,   0,   16'h0000, 0,   0,     16'h0030, 3'b000);

    cyc("load_0001",    0,   0,   1,   16'h0001, 0,   0,     16'h0001, 3'b000);
    cyc("start_0001",   0,   0,   0,   16'h0000, 1,   0,     16'h0001, 3'b100);
    cyc("rst_tick",     1,   1,   0,   16'h0000, 0,   0,     16'h0000, 3'b000);
    cyc("post_rst",     0,   0,   0,   16'h0000, 0,   0,     16'h0000, 3'b000);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
